// File: rtl/divisor_secuencial.sv
// divisor_secuencial
// Sequential 16-bit by 8-bit unsigned restoring divider with byte-wise
// operand entry. Each rising edge of btn latches sw into the next operand
// slot (dividend high byte, dividend low byte, divisor). A non-zero divisor
// starts a 16-clock restoring division; a zero divisor goes straight to
// DONE with a saturated quotient and the div_by_zero flag set. One more btn
// edge in DONE returns the block to LOAD_HI for the next entry.
//
// Ports
//   clk          in   clock, all state updates on its rising edge
//   resetCU      in   synchronous active-high reset
//   btn          in   operand-entry strobe (rising edge acted on)
//   sw[7:0]      in   operand byte, sampled with an accepted btn edge
//   quotient     out  16-bit result quotient, updated on entry to DONE
//   remainder    out  8-bit result remainder, updated on entry to DONE
//   busy         out  high while the division is running (CALC)
//   done         out  high while a result is presented (DONE)
//   div_by_zero  out  high in DONE when the divisor was zero
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOAD_HI  | waiting for the dividend high byte
// LOAD_LO  | waiting for the dividend low byte
// LOAD_DIV | waiting for the divisor byte
// CALC     | one restoring step per clock, 16 clocks total
// DONE     | result presented; next btn edge returns to LOAD_HI

module divisor_secuencial (
    input  logic        clk,
    input  logic        resetCU,
    input  logic        btn,
    input  logic [7:0]  sw,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    localparam logic [2:0] LOAD_HI  = 3'd0;
    localparam logic [2:0] LOAD_LO  = 3'd1;
    localparam logic [2:0] LOAD_DIV = 3'd2;
    localparam logic [2:0] CALC     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]  r_state;
    logic        r_btn_d;
    logic [15:0] r_dividend;
    logic [7:0]  r_d;
    logic [15:0] r_q;
    logic [8:0]  r_r;
    logic [3:0]  r_step;
    logic [15:0] r_quotient;
    logic [7:0]  r_remainder;
    logic        r_dbz;

    logic        w_evt;
    logic [8:0]  w_r_shift;
    logic        w_ge;
    logic [8:0]  w_r_next;
    logic [15:0] w_q_next;

    assign w_evt = btn & ~r_btn_d;

    // One restoring step: shift the next dividend bit into r, then subtract
    // the divisor when it fits. r[8] is always 0 after a step because r < d,
    // but folding it into the compare keeps the step correct on its own.
    assign w_r_shift = {r_r[7:0], r_q[15]};
    assign w_ge      = r_r[8] | (w_r_shift >= {1'b0, r_d});
    assign w_r_next  = w_ge ? (w_r_shift - {1'b0, r_d}) : w_r_shift;
    assign w_q_next  = {r_q[14:0], w_ge};

    always_ff @(posedge clk) begin
        if (resetCU) begin
            r_state     <= LOAD_HI;
            r_btn_d     <= 1'b0;
            r_dividend  <= 16'h0000;
            r_d         <= 8'h00;
            r_q         <= 16'h0000;
            r_r         <= 9'h000;
            r_step      <= 4'd0;
            r_quotient  <= 16'h0000;
            r_remainder <= 8'h00;
            r_dbz       <= 1'b0;
        end else begin
            r_btn_d <= btn;
            case (r_state)
                LOAD_HI: begin
                    if (w_evt) begin
                        r_dividend[15:8] <= sw;
                        r_state          <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (w_evt) begin
                        r_dividend[7:0] <= sw;
                        r_state         <= LOAD_DIV;
                    end
                end
                LOAD_DIV: begin
                    if (w_evt) begin
                        r_d <= sw;
                        if (sw != 8'h00) begin
                            r_q     <= r_dividend;
                            r_r     <= 9'h000;
                            r_step  <= 4'd0;
                            r_state <= CALC;
                        end else begin
                            r_quotient  <= 16'hFFFF;
                            r_remainder <= 8'h00;
                            r_dbz       <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                CALC: begin
                    // btn edges are deliberately not looked at here.
                    r_q <= w_q_next;
                    r_r <= w_r_next;
                    if (r_step == 4'd15) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next[7:0];
                        r_state     <= DONE;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                DONE: begin
                    // Acknowledge only; sw is not consumed on this edge.
                    if (w_evt) begin
                        r_dbz   <= 1'b0;
                        r_state <= LOAD_HI;
                    end
                end
                default: begin
                    r_state <= LOAD_HI;
                end
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign busy        = (r_state == CALC);
    assign done        = (r_state == DONE);
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divisor_secuencial.sv
module tb_divisor_secuencial;

    logic        clk;
    logic        resetCU;
    logic        btn;
    logic [7:0]  sw;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    divisor_secuencial dut (
        .clk         (clk),
        .resetCU     (resetCU),
        .btn         (btn),
        .sw          (sw),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    // One-cycle btn pulse; returns on the falling edge after the accepting edge.
    task automatic press(input logic [7:0] v);
        @(negedge clk);
        sw  = v;
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        sw  = 8'h5A;
    endtask

    // Called right after the divisor press. cyc counts falling edges until done.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic ack_done(input string name, input logic [15:0] held_q);
        press(8'hC3);
        n_checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ack: done=%b dbz=%b, required 0 0", name, done, div_by_zero);
        end
        n_checks++;
        if (quotient !== held_q) begin
            n_fail++;
            $display("FAIL %s_hold: quotient=%h, required %h", name, quotient, held_q);
        end
    endtask

    task automatic test_reset;
        resetCU = 1'b1;
        btn     = 1'b0;
        sw      = 8'hFF;
        repeat (2) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (quotient !== 16'h0000 || remainder !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_result: q=%h r=%h, required 0000 00", quotient, remainder);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b dbz=%b, required 0 0 0", busy, done, div_by_zero);
        end
        resetCU = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_divide(input string name, input logic [7:0] hi, input logic [7:0] lo,
                               input logic [7:0] dv, input logic [15:0] exp_q,
                               input logic [7:0] exp_r, input logic [15:0] prev_q);
        int cyc;
        int bcyc;
        press(hi);
        press(lo);
        n_checks++;
        if (quotient !== prev_q) begin
            n_fail++;
            $display("FAIL %s_hold_entry: quotient=%h, required %h", name, quotient, prev_q);
        end
        press(dv);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start: busy=%b done=%b, required 1 0", name, busy, done);
        end
        wait_done(cyc, bcyc);
        n_checks++;
        if (cyc != 16 || bcyc != 16) begin
            n_fail++;
            $display("FAIL %s_latency: done after %0d, busy for %0d, required 16 16", name, cyc, bcyc);
        end
        n_checks++;
        if (quotient !== exp_q || remainder !== exp_r) begin
            n_fail++;
            $display("FAIL %s_result: q=%h r=%h, required %h %h", name, quotient, remainder, exp_q, exp_r);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_flags: done=%b busy=%b dbz=%b, required 1 0 0", name, done, busy, div_by_zero);
        end
    endtask

    task automatic test_div_by_zero;
        ack_done("dbz", 16'h0000);
        press(8'h12);
        press(8'h34);
        press(8'h00);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_flags: done=%b busy=%b dbz=%b, required 1 0 1", done, busy, div_by_zero);
        end
        n_checks++;
        if (quotient !== 16'hFFFF || remainder !== 8'h00) begin
            n_fail++;
            $display("FAIL dbz_result: q=%h r=%h, required ffff 00", quotient, remainder);
        end
    endtask

    task automatic test_btn_held;
        int cyc;
        int bcyc;
        ack_done("held", 16'hFFFF);
        @(negedge clk);
        sw  = 8'h10;
        btn = 1'b1;
        repeat (5) @(negedge clk);
        btn = 1'b0;
        sw  = 8'h77;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL held_state: busy=%b done=%b, required 0 0", busy, done);
        end
        press(8'h00);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_not_div: busy=%b after low byte, required 0", busy);
        end
        press(8'h03);
        wait_done(cyc, bcyc);
        n_checks++;
        if (cyc != 16 || quotient !== 16'h0555 || remainder !== 8'h01) begin
            n_fail++;
            $display("FAIL held_result: cyc=%0d q=%h r=%h, required 16 0555 01", cyc, quotient, remainder);
        end
    endtask

    task automatic test_btn_in_calc;
        int cyc;
        ack_done("calcbtn", 16'h0555);
        press(8'h03);
        press(8'hE8);
        press(8'h07);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                btn = 1'b1;
                sw  = 8'h00;
            end
            if (cyc == 6) begin
                btn = 1'b0;
                sw  = 8'h5A;
            end
        end
        n_checks++;
        if (cyc != 16 || quotient !== 16'h008E || remainder !== 8'h06) begin
            n_fail++;
            $display("FAIL calcbtn_result: cyc=%0d q=%h r=%h, required 16 008e 06", cyc, quotient, remainder);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL calcbtn_not_queued: done=%b, required 1", done);
        end
    endtask

    task automatic test_reset_mid_calc;
        int cyc;
        int bcyc;
        ack_done("rstcalc", 16'h0ABC);
        press(8'h03);
        press(8'hE8);
        press(8'h07);
        repeat (7) @(negedge clk);
        resetCU = 1'b1;
        btn     = 1'b1;
        sw      = 8'h03;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL rstcalc_flags: busy=%b done=%b dbz=%b, required 0 0 0", busy, done, div_by_zero);
        end
        n_checks++;
        if (quotient !== 16'h0000 || remainder !== 8'h00) begin
            n_fail++;
            $display("FAIL rstcalc_result: q=%h r=%h, required 0000 00", quotient, remainder);
        end
        @(negedge clk);
        resetCU = 1'b0;
        @(negedge clk);
        btn = 1'b0;
        sw  = 8'h5A;
        press(8'hE8);
        press(8'h07);
        wait_done(cyc, bcyc);
        n_checks++;
        if (cyc != 16 || bcyc != 16 || quotient !== 16'h008E || remainder !== 8'h06) begin
            n_fail++;
            $display("FAIL rstcalc_fresh: cyc=%0d busy=%0d q=%h r=%h, required 16 16 008e 06",
                     cyc, bcyc, quotient, remainder);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetCU  = 1'b1;
        btn      = 1'b0;
        sw       = 8'h00;
        test_reset();
        test_divide("d1000_7", 8'h03, 8'hE8, 8'h07, 16'h008E, 8'h06, 16'h0000);
        ack_done("a1", 16'h008E);
        test_divide("dffff_1", 8'hFF, 8'hFF, 8'h01, 16'hFFFF, 8'h00, 16'h008E);
        ack_done("a2", 16'hFFFF);
        test_divide("d5_9", 8'h00, 8'h05, 8'h09, 16'h0000, 8'h05, 16'hFFFF);
        test_div_by_zero();
        test_btn_held();
        test_btn_in_calc();
        ack_done("a3", 16'h008E);
        test_divide("back_to_back", 8'hAB, 8'hCD, 8'h10, 16'h0ABC, 8'h0D, 16'h008E);
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
